// File: rtl/gshare_predictor_pkg.sv
// Shared types for the gshare branch predictor: 2-bit counters, outcomes, sweep FSM states.
// Optional GSHARE_INIT_SWEEP_EN selects the RAM-plus-sweep PHT instead of the reset flop array.
package gshare_predictor_pkg;

    typedef logic [1:0] bp_counter_t;

    localparam bp_counter_t BP_STRONG_NT = 2'b00;
    localparam bp_counter_t BP_WEAK_NT   = 2'b01;
    localparam bp_counter_t BP_WEAK_T    = 2'b10;
    localparam bp_counter_t BP_STRONG_T  = 2'b11;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } pht_state_t;

    function automatic bp_counter_t bp_counter_next(input bp_counter_t cnt,
                                                    input branch_outcome_t outcome);
        bp_counter_t result;
        result = cnt;
        if (outcome == TAKEN) begin
            if (cnt != BP_STRONG_T) result = cnt + 2'd1;
        end else begin
            if (cnt != BP_STRONG_NT) result = cnt - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: async read port, saturating read-modify-write port.
// GSHARE_INIT_SWEEP_EN builds it as an unreset RAM cleared by a SWEEP/RUN FSM after reset.
module gshare_pht
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output bp_counter_t           rd_counter,
    input  logic                  wr_valid,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  branch_outcome_t       wr_outcome,
    output logic                  ready
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bp_counter_t pht_q [ENTRIES];

    assign rd_counter = pht_q[rd_index];

`ifdef GSHARE_INIT_SWEEP_EN

    pht_state_t            state;
    pht_state_t            state_next;
    logic [INDEX_BITS-1:0] sweep_index;
    logic                  we;
    logic [INDEX_BITS-1:0] waddr;
    bp_counter_t           wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SWEEP;
            sweep_index <= '0;
        end else begin
            state <= state_next;
            if (state == SWEEP) sweep_index <= sweep_index + INDEX_BITS'(1);
        end
    end

    // The single write port is owned by the sweep until every entry holds weakly not-taken.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = wr_index;
        wdata      = bp_counter_next(pht_q[wr_index], wr_outcome);
        ready      = 1'b0;
        case (state)
            SWEEP: begin
                we    = 1'b1;
                waddr = sweep_index;
                wdata = BP_WEAK_NT;
                if (sweep_index == '1) state_next = RUN;
            end
            RUN: begin
                ready = 1'b1;
                we    = wr_valid;
            end
            default: state_next = SWEEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) pht_q[waddr] <= wdata;
    end

`else

    logic ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= BP_WEAK_NT;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (wr_valid) pht_q[wr_index] <= bp_counter_next(pht_q[wr_index], wr_outcome);
        end
    end

    assign ready = ready_q;

`endif

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC/GHR hashing, speculative GHR with mispredict repair.
// GSHARE_INIT_SWEEP_EN selects the swept-RAM PHT variant inside gshare_pht.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_BITS   = 10,
    parameter int HISTORY_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    input  logic [31:0]             i_req_pc,
    output logic                    o_req_prediction,
    output logic [HISTORY_BITS-1:0] o_req_history,
    input  logic                    i_fb_valid,
    input  logic [31:0]             i_fb_pc,
    input  logic [HISTORY_BITS-1:0] i_fb_history,
    input  logic                    i_fb_prediction,
    input  logic                    i_fb_outcome,
    output logic                    o_ready
);

    logic [HISTORY_BITS-1:0] ghr;
    logic [INDEX_BITS-1:0]   req_index;
    logic [INDEX_BITS-1:0]   fb_index;
    bp_counter_t             req_counter;
    logic                    ready;
    logic                    fb_apply;
    logic                    recover;
    logic                    unused_bits;

    assign req_index = i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign fb_index  = i_fb_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(i_fb_history);

    assign o_req_prediction = ready & req_counter[1];
    assign o_req_history    = ghr;
    assign o_ready          = ready;

    assign fb_apply = ready & i_fb_valid;
    assign recover  = fb_apply & (i_fb_prediction != i_fb_outcome);

    assign unused_bits = ^{i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0],
                           i_fb_pc[31:INDEX_BITS+2], i_fb_pc[1:0],
                           i_fb_history[HISTORY_BITS-1], req_counter[0]};

    // A mispredict means the same-cycle request is on the wrong path, so its shift is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (recover) begin
            ghr <= {i_fb_history[HISTORY_BITS-2:0], i_fb_outcome};
        end else if (ready && i_req_valid) begin
            ghr <= {ghr[HISTORY_BITS-2:0], o_req_prediction};
        end
    end

    gshare_pht #(
        .INDEX_BITS(INDEX_BITS)
    ) u_pht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (req_index),
        .rd_counter(req_counter),
        .wr_valid  (fb_apply),
        .wr_index  (fb_index),
        .wr_outcome(branch_outcome_t'(i_fb_outcome)),
        .ready     (ready)
    );

endmodule
